// File: rtl/dsp_pkg.sv
// Shared types and constants for the channelizer front-end blocks.
package dsp_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_RUN   = 2'd1,
        SCHED_DRAIN = 2'd2,
        SCHED_FLUSH = 2'd3
    } channelizer_sched_state_t;

    localparam int CHAN_SCHED_DEFAULT_SPACING = 4;

    // Counter width able to hold (value - 1), never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/channelizer_input_fifo.sv
// Synchronous sample FIFO buffering the live primary stream; a write while full
// is still accepted when a pop frees a slot in the same cycle.
module channelizer_input_fifo
    import dsp_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = clog2_min1(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd_en = i_rd && !o_empty;
    assign w_wr_en = i_wr && (!o_full || w_rd_en);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/channelizer_input_scheduler.sv
// Feeds the polyphase channelizer from the primary FIFO or the playback source,
// enforcing minimum sample spacing and zero-sample history flushes.
//   state | meaning
//   IDLE  | no source selected; flush requests start FLUSH
//   RUN   | emit from latched source whenever spacing expired
//   DRAIN | finish spacing interval, empty primary FIFO
//   FLUSH | emit FLUSH_COUNT zero samples at fixed spacing
module channelizer_input_scheduler
    import dsp_pkg::*;
#(
    parameter int DATA_WIDTH     = 12,
    parameter int SAMPLE_SPACING = CHAN_SCHED_DEFAULT_SPACING,
    parameter int FIFO_DEPTH     = 16,
    parameter int FLUSH_COUNT    = 384
) (
    input  logic                               Clk,
    input  logic                               Rst_n,
    input  logic                               Enable,
    input  logic                               Source_select,
    input  logic                               Flush_req,
    input  logic                               Primary_valid,
    input  logic signed [1:0][DATA_WIDTH-1:0]  Primary_data,
    input  logic                               Playback_valid,
    input  logic signed [1:0][DATA_WIDTH-1:0]  Playback_data,
    output logic                               Playback_ready,
    output logic                               Output_valid,
    output logic signed [1:0][DATA_WIDTH-1:0]  Output_data,
    output logic                               Active_source,
    output logic                               Flushing,
    output logic                               Error_overflow
);

    localparam int SAMPLE_W = 2 * DATA_WIDTH;
    localparam int SW       = clog2_min1(SAMPLE_SPACING);
    localparam int FW       = clog2_min1(FLUSH_COUNT + 1);
    localparam logic [SW-1:0] SPACING_RELOAD = SW'(SAMPLE_SPACING - 1);
    localparam logic [FW-1:0] FLUSH_LOAD     = FW'(FLUSH_COUNT);

    channelizer_sched_state_t r_state;
    logic [SW-1:0]       r_space_cnt;
    logic [FW-1:0]       r_flush_left;
    logic                r_flush_pend;
    logic                r_active;
    logic                r_out_valid;
    logic [SAMPLE_W-1:0] r_out_data;
    logic                r_err;
    logic                r_pb_ready_q;

    logic                w_space_done;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [SAMPLE_W-1:0] w_fifo_data;
    logic                w_pop;
    logic                w_pb_ready;
    logic                w_pb_xfer;
    logic                w_flush_emit;
    logic                w_emit;
    logic                w_drop;
    logic [SAMPLE_W-1:0] w_emit_data;

    channelizer_input_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (Clk),
        .i_rst_n   (Rst_n),
        .i_wr      (Primary_valid),
        .i_wr_data (Primary_data),
        .i_rd      (w_pop),
        .o_rd_data (w_fifo_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    assign w_space_done = (r_space_cnt == '0);
    assign w_pop        = w_space_done && !r_active && !w_fifo_empty &&
                          ((r_state == SCHED_RUN) || (r_state == SCHED_DRAIN));
    // Ready drops for a cycle after an unanswered offer so it never stays high.
    assign w_pb_ready   = (r_state == SCHED_RUN) && r_active && w_space_done && !r_pb_ready_q;
    assign w_pb_xfer    = w_pb_ready && Playback_valid;
    assign w_flush_emit = (r_state == SCHED_FLUSH) && w_space_done && (r_flush_left != '0);
    assign w_emit       = w_pop || w_pb_xfer || w_flush_emit;
    assign w_drop       = Primary_valid && w_fifo_full && !w_pop;

    always_comb begin
        w_emit_data = '0;
        if (w_pop)          w_emit_data = w_fifo_data;
        else if (w_pb_xfer) w_emit_data = Playback_data;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= SCHED_IDLE;
            r_space_cnt  <= '0;
            r_flush_left <= '0;
            r_flush_pend <= 1'b0;
            r_active     <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_err        <= 1'b0;
            r_pb_ready_q <= 1'b0;
        end else begin
            r_out_valid  <= w_emit;
            r_out_data   <= w_emit_data;
            r_err        <= w_drop;
            r_pb_ready_q <= w_pb_ready;

            if (w_emit)             r_space_cnt <= SPACING_RELOAD;
            else if (!w_space_done) r_space_cnt <= r_space_cnt - SW'(1);

            if (w_flush_emit) r_flush_left <= r_flush_left - FW'(1);
            if (Flush_req && (r_state != SCHED_FLUSH)) r_flush_pend <= 1'b1;

            case (r_state)
                SCHED_IDLE: begin
                    if (Flush_req || r_flush_pend) begin
                        r_state      <= SCHED_FLUSH;
                        r_flush_left <= FLUSH_LOAD;
                    end else if (Enable) begin
                        r_active <= Source_select;
                        r_state  <= SCHED_RUN;
                    end
                end
                SCHED_RUN: begin
                    if (!Enable || Flush_req) r_state <= SCHED_DRAIN;
                end
                SCHED_DRAIN: begin
                    if (w_space_done && (r_active || w_fifo_empty)) begin
                        if (r_flush_pend || Flush_req) begin
                            r_state      <= SCHED_FLUSH;
                            r_flush_left <= FLUSH_LOAD;
                        end else begin
                            r_state <= SCHED_IDLE;
                        end
                    end
                end
                SCHED_FLUSH: begin
                    if (r_flush_left == '0) begin
                        r_state      <= SCHED_IDLE;
                        r_flush_pend <= 1'b0;
                    end
                end
                default: r_state <= SCHED_IDLE;
            endcase
        end
    end

    assign Playback_ready = w_pb_ready;
    assign Output_valid   = r_out_valid;
    assign Output_data    = r_out_data;
    assign Active_source  = r_active;
    assign Flushing       = (r_state == SCHED_FLUSH);
    assign Error_overflow = r_err;

endmodule

// File: doc/channelizer_input_scheduler.md
# channelizer_input_scheduler

Sequences the complex sample stream into the polyphase channelizer (`Input_valid`/`Input_data`). It selects between a live, non-stallable primary stream (buffered in a FIFO) and a stallable playback source with a ready/valid handshake. It enforces the channelizer's minimum inter-sample spacing and runs a zero-sample flush sequence that clears the filter history before a source switch.

## Interface
- `DATA_WIDTH`, 12: I/Q sample width, signed.
- `SAMPLE_SPACING`, 4: minimum cycles between `Output_valid` pulses; must be ≥1.
- `FIFO_DEPTH`, 16: primary buffer depth in samples; power of two.
- `FLUSH_COUNT`, 384: zero samples emitted per flush (≥ NUM_CHANNELS × NUM_COEFS_PER_CHANNEL); ≥1.
- `Clk` in 1: single clock.
- `Rst_n` in 1: reset, asynchronous, active-low.
- `Enable` in 1: 0 stops new selections and drains to IDLE.
- `Source_select` in 1: 0 = primary, 1 = playback; sampled only in IDLE.
- `Flush_req` in 1: one-cycle pulse, requests a flush.
- `Primary_valid` in 1: primary sample strobe, no backpressure.
- `Primary_data` in 2×DATA_WIDTH signed: [0]=I, [1]=Q.
- `Playback_valid` in 1: playback sample offered.
- `Playback_data` in 2×DATA_WIDTH signed: [0]=I, [1]=Q.
- `Playback_ready` out 1: playback sample accepted when valid && ready.
- `Output_valid` out 1: to channelizer `Input_valid`.
- `Output_data` out 2×DATA_WIDTH signed: to channelizer `Input_data`.
- `Active_source` out 1: source currently latched.
- `Flushing` out 1: high in FLUSH state.
- `Error_overflow` out 1: one-cycle pulse when a primary sample is dropped (FIFO full).

## Operation
- FSM states: IDLE, RUN, DRAIN, FLUSH.
- IDLE:
  - If `Flush_req` is seen (or pending), go to FLUSH.
  - Otherwise, if `Enable`=1, latch `Source_select` into `Active_source` and go to RUN.
  - `Flush_req` has priority over entering RUN.
- RUN: emits one sample whenever the spacing counter has expired and the active source has data.
  - Primary: pop FIFO head.
  - Playback: assert `Playback_ready` for exactly that cycle; the sample transfers on valid && ready.
- `Enable`=0, or `Flush_req` pulse in RUN: go to DRAIN.
- DRAIN: finishes the in-progress spacing interval. The primary FIFO keeps emitting until empty; playback stops immediately. Then go to FLUSH if a flush is pending, else IDLE.
- FLUSH: emits `FLUSH_COUNT` samples of I=Q=0 at exactly `SAMPLE_SPACING` intervals, then goes to IDLE and clears the pending flag.
- `Flush_req` during FLUSH is ignored; the count does not restart.
- Primary FIFO writes whenever `Primary_valid`=1, in any state, including FLUSH.
  - When full, the sample is dropped and `Error_overflow` pulses on the following cycle.
  - A write and a pop in the same cycle while full is accepted (no drop).
- Spacing counter:
  - Loads `SAMPLE_SPACING`-1 on each `Output_valid`.
  - Decrements to 0, saturating.
  - An output is permitted only when the counter is 0.
- Data path: sample data is passed unmodified; no width change or rounding.

## Timing
- Reset values: state IDLE, `Output_valid`=0, `Output_data`=0, `Playback_ready`=0, `Active_source`=0, `Flushing`=0, `Error_overflow`=0, FIFO empty, spacing counter 0, flush pending 0.
- Reset mid-operation discards FIFO contents and aborts any flush immediately (asynchronous assertion).
- `Output_valid` and `Output_data` are registered.
- `Output_data` is zeroed on every cycle that `Output_valid`=0.
- Primary latency: sample written at cycle N into an empty FIFO in RUN with the counter at 0 → `Output_valid` at N+2.
- Playback latency: handshake at cycle N → `Output_valid` at N+1.
- `Playback_ready` is combinationally independent of `Playback_valid`.
- `Playback_ready` is never high on two consecutive cycles when `SAMPLE_SPACING`>1.
- State transitions take effect the cycle after the triggering input.

## Structure
- Sub-module `channelizer_input_fifo`: synchronous FIFO, DATA_WIDTH×2 wide, `FIFO_DEPTH` deep, with full/empty flags and an async active-low reset.
- `dsp_pkg` gains:
  - `channelizer_sched_state_t` (the four states);
  - `CHAN_SCHED_DEFAULT_SPACING` = 4.

## Test plan
- Primary stream, one sample every 4 cycles, values (i,i+1) for i=0..99, `SAMPLE_SPACING`=4 → 100 outputs in order, with no `Error_overflow`.
- Primary burst of 20 back-to-back samples, `FIFO_DEPTH`=16 → at most 4 `Error_overflow` pulses, outputs spaced exactly 4 cycles, and output count = 20 − drops.
- Playback, `Playback_valid` held high with an incrementing counter → `Playback_ready` one cycle in 4, each output equal to the accepted value, and 1-cycle latency.
- `Flush_req` mid-RUN with 5 samples in FIFO → 5 samples drained, then `Flushing`=1 for 384 zero outputs at 4-cycle spacing, then IDLE.
- Switching sources: `Enable`=0, set `Source_select`=1, `Flush_req`, then `Enable`=1 → flush completes before the first playback handshake, and `Active_source`=1.
- `Rst_n` asserted during FLUSH → all outputs return to reset values in the same cycle; after release the bench sees IDLE and no residual output.
